// File: rtl/ibex_fetch_queue.sv
// Decoupling queue between the fetch port and the IF/ID register, with an
// optional same-cycle fall-through, flush on redirect and a sequential-PC check.
module ibex_fetch_queue #(
  parameter int Depth       = 4,
  parameter bit FallThrough = 1'b1,
  parameter bit PCIncrCheck = 1'b0,
  parameter int CntW        = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_rdata_i,
  input  logic [31:0]     in_addr_i,
  input  logic            in_err_i,
  input  logic            in_err_plus2_i,
  input  logic            in_bp_taken_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     out_rdata_o,
  output logic [31:0]     out_addr_o,
  output logic            out_err_o,
  output logic            out_err_plus2_o,
  output logic            out_bp_taken_o,
  output logic [CntW-1:0] occupancy_o,
  output logic            pc_mismatch_alert_o
);

  localparam int PtrW = $clog2(Depth);

  logic [31:0]     r_mem_rdata [Depth];
  logic [31:0]     r_mem_addr  [Depth];
  logic            r_mem_err   [Depth];
  logic            r_mem_plus2 [Depth];
  logic            r_mem_bp    [Depth];

  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;

  logic            w_empty;
  logic            w_use_in;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;

  assign w_empty  = (r_count == '0);
  assign w_use_in = FallThrough & w_empty;
  assign w_bypass = FallThrough & in_valid_i & out_ready_i & w_empty;

  // Ready depends only on stored state, so a full queue never pushes, even while popping.
  assign in_ready_o  = (r_count != CntW'(Depth));
  assign out_valid_o = ~flush_i & (~w_empty | (FallThrough & in_valid_i));
  assign occupancy_o = r_count;

  assign w_push = in_valid_i & in_ready_o & ~flush_i & ~w_bypass;
  assign w_pop  = out_valid_o & out_ready_i & ~flush_i & ~w_bypass;

  assign out_rdata_o     = w_use_in ? in_rdata_i     : r_mem_rdata[r_rptr];
  assign out_addr_o      = w_use_in ? in_addr_i      : r_mem_addr[r_rptr];
  assign out_err_o       = w_use_in ? in_err_i       : r_mem_err[r_rptr];
  assign out_err_plus2_o = w_use_in ? in_err_plus2_i : r_mem_plus2[r_rptr];
  assign out_bp_taken_o  = w_use_in ? in_bp_taken_i  : r_mem_bp[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_rdata[r_wptr] <= in_rdata_i;
      r_mem_addr[r_wptr]  <= in_addr_i;
      r_mem_err[r_wptr]   <= in_err_i;
      r_mem_plus2[r_wptr] <= in_err_plus2_i;
      r_mem_bp[r_wptr]    <= in_bp_taken_i;
    end
  end

  // Depth need not be a power of two, so pointers wrap on an explicit compare.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + PtrW'(1);
      end
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  if (PCIncrCheck) begin : g_pc_chk
    logic        r_trk_vld;
    logic        r_alert;
    logic        r_seq_ok;
    logic [2:0]  r_last_inc;
    logic [31:0] r_last_addr;
    logic        w_accept;
    logic [31:0] w_exp_addr;

    assign w_accept   = (w_pop | w_bypass) & ~flush_i;
    assign w_exp_addr = r_last_addr + {29'b0, r_last_inc};

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_trk_vld <= 1'b0;
        r_alert   <= 1'b0;
      end else begin
        r_alert <= w_accept & r_trk_vld & r_seq_ok & (out_addr_o != w_exp_addr);
        if (flush_i) begin
          r_trk_vld <= 1'b0;
        end else if (w_accept) begin
          r_trk_vld <= 1'b1;
        end
      end
    end

    // Compressed words advance by 2; an errored fetch is treated as a full word.
    always_ff @(posedge clk_i) begin
      if (w_accept) begin
        r_last_addr <= out_addr_o;
        r_last_inc  <= ((out_rdata_o[1:0] != 2'b11) && !out_err_o) ? 3'd2 : 3'd4;
        r_seq_ok    <= ~out_bp_taken_o;
      end
    end

    assign pc_mismatch_alert_o = r_alert;
  end else begin : g_no_pc_chk
    assign pc_mismatch_alert_o = 1'b0;
  end

endmodule
